// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the LC-3 memory/IO sequencer: device addresses,
// INMUX_SEL codes, FSM state encoding and the address decode record.
package mem_io_ctrl_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    typedef enum logic [1:0] {
        SEL_KBDR = 2'b00,
        SEL_KBSR = 2'b01,
        SEL_DSR  = 2'b10,
        SEL_MEM  = 2'b11
    } inmux_sel_t;

    typedef enum logic [1:0] {
        DEV_KBSR = 2'd0,
        DEV_KBDR = 2'd1,
        DEV_DSR  = 2'd2,
        DEV_DDR  = 2'd3
    } dev_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DEV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic    is_dev;
        dev_id_t dev_id;
    } addr_dec_t;

    // DDR is write-only, so a DDR read steers the memory path onto the bus.
    function automatic inmux_sel_t sel_for(input addr_dec_t dec);
        inmux_sel_t sel;
        sel = SEL_MEM;
        if (dec.is_dev) begin
            case (dec.dev_id)
                DEV_KBSR: sel = SEL_KBSR;
                DEV_KBDR: sel = SEL_KBDR;
                DEV_DSR:  sel = SEL_DSR;
                default:  sel = SEL_MEM;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_io_ctrl_addr_decode.sv
// Combinational MAR decode: flags the four memory-mapped device registers
// and identifies which one; every other address is main memory.
module mem_io_ctrl_addr_decode
    import mem_io_ctrl_pkg::*;
(
    input  logic [15:0] i_mar,
    output addr_dec_t   o_dec
);

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned and infers a latch.
        o_dec.is_dev = 1'b0;
        o_dec.dev_id = DEV_KBSR;
        case (i_mar)
            ADDR_KBSR: begin o_dec.is_dev = 1'b1; o_dec.dev_id = DEV_KBSR; end
            ADDR_KBDR: begin o_dec.is_dev = 1'b1; o_dec.dev_id = DEV_KBDR; end
            ADDR_DSR:  begin o_dec.is_dev = 1'b1; o_dec.dev_id = DEV_DSR;  end
            ADDR_DDR:  begin o_dec.is_dev = 1'b1; o_dec.dev_id = DEV_DDR;  end
            default:   begin o_dec.is_dev = 1'b0; o_dec.dev_id = DEV_KBSR; end
        endcase
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// LC-3 memory/IO sequencer: accepts a request in IDLE, runs MEM_WAIT memory
// cycles or one device cycle, then pulses R for one cycle in DONE.
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    output logic [1:0]  INMUX_SEL,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic        LD_KBSR,
    output logic        LD_DSR,
    output logic        LD_DDR,
    output logic        RD_KBDR,
    output logic        R
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_WAIT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic       r_wr;
    dev_id_t    r_dev_id;
    inmux_sel_t r_sel;
    addr_dec_t  w_dec;
    logic       w_accept;

    mem_io_ctrl_addr_decode u_decode (
        .i_mar (MAR),
        .o_dec (w_dec)
    );

    assign w_accept = (r_state == ST_IDLE) && MIO_EN;

    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (MIO_EN) w_next_state = w_dec.is_dev ? ST_DEV : ST_MEM;
            ST_MEM:  if (r_cnt == 4'd0) w_next_state = ST_DONE;
            ST_DEV:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are captured once; INMUX_SEL then holds through DONE for the MDR load.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= 4'd0;
            r_wr     <= 1'b0;
            r_dev_id <= DEV_KBSR;
            r_sel    <= SEL_MEM;
        end else if (w_accept) begin
            r_cnt    <= w_dec.is_dev ? 4'd0 : CNT_LOAD;
            r_wr     <= R_W;
            r_dev_id <= w_dec.dev_id;
            r_sel    <= sel_for(w_dec);
        end else if ((r_state == ST_MEM) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        INMUX_SEL = r_sel;
        MEM_EN    = (r_state == ST_MEM);
        MEM_WE    = (r_state == ST_MEM) && r_wr;
        LD_KBSR   = (r_state == ST_DEV) &&  r_wr && (r_dev_id == DEV_KBSR);
        LD_DSR    = (r_state == ST_DEV) &&  r_wr && (r_dev_id == DEV_DSR);
        LD_DDR    = (r_state == ST_DEV) &&  r_wr && (r_dev_id == DEV_DDR);
        RD_KBDR   = (r_state == ST_DEV) && !r_wr && (r_dev_id == DEV_KBDR);
        R         = (r_state == ST_DONE);
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: table-driven single accesses with a
// scoreboard, plus back-to-back, mid-access reset and MEM_WAIT=1 sequences.
module tb_mem_io_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MAR;

    logic [1:0] sel4, sel1;
    logic       men4, mwe4, ldkbsr4, lddsr4, ldddr4, rdkbdr4, r4;
    logic       men1, mwe1, ldkbsr1, lddsr1, ldddr1, rdkbdr1, r1;

    mem_io_ctrl #(.MEM_WAIT(4)) u_dut4 (
        .CLK(CLK), .RESET(RESET), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR),
        .INMUX_SEL(sel4), .MEM_EN(men4), .MEM_WE(mwe4), .LD_KBSR(ldkbsr4),
        .LD_DSR(lddsr4), .LD_DDR(ldddr4), .RD_KBDR(rdkbdr4), .R(r4)
    );

    mem_io_ctrl #(.MEM_WAIT(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR),
        .INMUX_SEL(sel1), .MEM_EN(men1), .MEM_WE(mwe1), .LD_KBSR(ldkbsr1),
        .LD_DSR(lddsr1), .LD_DDR(ldddr1), .RD_KBDR(rdkbdr1), .R(r1)
    );

    always #5 CLK = ~CLK;

    // Observed outputs of whichever instance is under test.
    bit         use1 = 1'b0;
    logic [1:0] o_sel;
    logic       o_men, o_mwe, o_r;
    logic [3:0] o_strb;  // {LD_KBSR, LD_DSR, LD_DDR, RD_KBDR}
    assign o_sel  = use1 ? sel1 : sel4;
    assign o_men  = use1 ? men1 : men4;
    assign o_mwe  = use1 ? mwe1 : mwe4;
    assign o_r    = use1 ? r1   : r4;
    assign o_strb = use1 ? {ldkbsr1, lddsr1, ldddr1, rdkbdr1}
                         : {ldkbsr4, lddsr4, ldddr4, rdkbdr4};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] mar;
        logic        rw;
        logic [1:0]  sel;
        logic [3:0]  strb;
        logic        is_mem;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [3:0] strb;
        int         mem_cycles;
        int         we_cycles;
        int         r_cycle;
    } exp_t;

    exp_t sb_q[$];

    function automatic vec_t mk(input string n, input logic [15:0] a, input logic w,
                                input logic [1:0] s, input logic [3:0] st, input logic m);
        vec_t v;
        v.name = n; v.mar = a; v.rw = w; v.sel = s; v.strb = st; v.is_mem = m;
        return v;
    endfunction

    // One isolated access: request for one cycle, then watch until R and one idle cycle beyond.
    task automatic run_access(input vec_t v, input int wait_n);
        exp_t e;
        int   mem_n, we_n, first_mem, strb_n, r_cyc;
        logic [3:0] strb1;
        logic [1:0] sel_done;
        bit   done;
        mem_n = 0; we_n = 0; first_mem = 0; strb_n = 0; r_cyc = 0;
        strb1 = 4'h0; sel_done = 2'b00; done = 1'b0;

        @(negedge CLK);
        MAR = v.mar; R_W = v.rw; MIO_EN = 1'b1;
        e.name       = v.name;
        e.sel        = v.sel;
        e.strb       = v.strb;
        e.mem_cycles = v.is_mem ? wait_n : 0;
        e.we_cycles  = (v.is_mem && v.rw) ? wait_n : 0;
        e.r_cycle    = v.is_mem ? wait_n + 1 : 2;
        sb_q.push_back(e);

        @(negedge CLK);
        MIO_EN = 1'b0; R_W = ~v.rw; MAR = v.mar ^ 16'h0102;
        for (int c = 1; c <= 32 && !done; c++) begin
            if (c > 1) @(negedge CLK);
            if (o_men) begin
                mem_n++;
                if (first_mem == 0) first_mem = c;
            end
            if (o_mwe) we_n++;
            if (c == 1) strb1 = o_strb;
            strb_n += $countones(o_strb);
            if (o_r) begin
                r_cyc = c; sel_done = o_sel; done = 1'b1;
            end
        end
        check({v.name, "_timeout"}, {31'd0, done}, 32'd1);

        e = sb_q.pop_front();
        check({e.name, "_r_cycle"},   r_cyc,    e.r_cycle);
        check({e.name, "_sel"},       sel_done, e.sel);
        check({e.name, "_strb_c1"},   strb1,    e.strb);
        check({e.name, "_strb_cnt"},  strb_n,   $countones(e.strb));
        check({e.name, "_mem_en"},    mem_n,    e.mem_cycles);
        check({e.name, "_mem_we"},    we_n,     e.we_cycles);
        check({e.name, "_mem_first"}, first_mem, (e.mem_cycles > 0) ? 1 : 0);

        @(negedge CLK);
        check({e.name, "_r_single"},  {31'd0, o_r}, 32'd0);
        check({e.name, "_sel_hold"},  o_sel,    e.sel);
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; MAR = 16'h0000;

        vecs[0]  = mk("rd_mem_3000",  16'h3000, 1'b0, 2'b11, 4'b0000, 1'b1);
        vecs[1]  = mk("wr_ddr",       16'hFE06, 1'b1, 2'b11, 4'b0010, 1'b0);
        vecs[2]  = mk("rd_kbdr",      16'hFE02, 1'b0, 2'b00, 4'b0001, 1'b0);
        vecs[3]  = mk("wr_kbdr_drop", 16'hFE02, 1'b1, 2'b00, 4'b0000, 1'b0);
        vecs[4]  = mk("wr_kbsr",      16'hFE00, 1'b1, 2'b01, 4'b1000, 1'b0);
        vecs[5]  = mk("rd_kbsr",      16'hFE00, 1'b0, 2'b01, 4'b0000, 1'b0);
        vecs[6]  = mk("wr_dsr",       16'hFE04, 1'b1, 2'b10, 4'b0100, 1'b0);
        vecs[7]  = mk("rd_dsr",       16'hFE04, 1'b0, 2'b10, 4'b0000, 1'b0);
        vecs[8]  = mk("rd_ddr",       16'hFE06, 1'b0, 2'b11, 4'b0000, 1'b0);
        vecs[9]  = mk("wr_mem_3000",  16'h3000, 1'b1, 2'b11, 4'b0000, 1'b1);
        vecs[10] = mk("rd_mem_fffe",  16'hFFFE, 1'b0, 2'b11, 4'b0000, 1'b1);
        vecs[11] = mk("wr_mem_fe01",  16'hFE01, 1'b1, 2'b11, 4'b0000, 1'b1);
        vecs[12] = mk("rd_mem_fe08",  16'hFE08, 1'b0, 2'b11, 4'b0000, 1'b1);

        // Reset values, observed before any clock edge.
        #3;
        check("reset_outs", {o_sel, o_men, o_mwe, o_strb, o_r}, {2'b11, 1'b0, 1'b0, 4'b0000, 1'b0});
        @(negedge CLK);
        RESET = 1'b0;

        foreach (vecs[i]) run_access(vecs[i], 4);

        // Back-to-back: MIO_EN held through a memory read then a KBSR read.
        @(negedge CLK);
        MAR = 16'h4000; R_W = 1'b0; MIO_EN = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            logic       er, em;
            logic [1:0] es;
            @(negedge CLK);
            if (c == 1) MAR = 16'hFE00;
            if (c == 7) MIO_EN = 1'b0;
            er = (c == 5) || (c == 8);
            em = (c <= 4);
            es = (c >= 7 && c <= 9) ? 2'b01 : 2'b11;
            check($sformatf("b2b_c%0d", c), {o_r, o_men, o_sel, o_strb}, {er, em, es, 4'b0000});
        end

        // Reset asserted in the second MEM cycle.
        @(negedge CLK);
        MAR = 16'h3000; R_W = 1'b1; MIO_EN = 1'b1;
        @(negedge CLK);
        MIO_EN = 1'b0;
        @(negedge CLK);
        check("rst_pre_mem_en", {31'd0, o_men}, 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("rst_async_outs", {o_sel, o_men, o_mwe, o_strb, o_r}, {2'b11, 1'b0, 1'b0, 4'b0000, 1'b0});
        @(negedge CLK);
        RESET = 1'b0;
        begin
            int r_seen, m_seen;
            r_seen = 0; m_seen = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge CLK);
                r_seen += o_r;
                m_seen += o_men;
            end
            check("rst_no_r", r_seen, 0);
            check("rst_no_mem_en", m_seen, 0);
        end
        run_access(vecs[2], 4);
        run_access(vecs[0], 4);

        // MEM_WAIT=1 instance: write at xFFFE after a fresh reset.
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        use1 = 1'b1;
        run_access(mk("w1_wr_fffe", 16'hFFFE, 1'b1, 2'b11, 4'b0000, 1'b1), 1);

        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
